// File: rtl/hwjsoc_cpu_b_oci_dct_packer_if.sv
// Atom-input and packet-output channels of the CPU-B OCI DCT packer.
// Handshake (both channels): data moves on a rising clk edge where valid & ready are both high.
// While valid is high and ready is low, the sender holds its data stable.
interface hwjsoc_cpu_b_oci_dct_packer_if #(
    parameter int ATOM_W = 2,
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4
);
    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;
    logic              atom_ready;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              dct_valid;
    logic              dct_ready;

    // master: the packer itself (sinks atoms, sources packets)
    modport master (
        input  atom_valid, atom_data, dct_ready,
        output atom_ready, dct_buffer, dct_count, dct_valid
    );

    // slave: the trace source / capture consumer side
    modport slave (
        output atom_valid, atom_data, dct_ready,
        input  atom_ready, dct_buffer, dct_count, dct_valid
    );
endinterface

// File: rtl/hwjsoc_cpu_b_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit packets of up to 15 atoms and
// sequences the end-of-test drain (RUN -> DRAIN -> ENDED).
module hwjsoc_cpu_b_oci_dct_packer #(
    parameter int ATOM_W    = 2,
    parameter int MAX_ATOMS = 15,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       test_ending_in,
    output logic       test_ending,
    output logic       test_has_ended,
    output logic [1:0] state_dbg,
    hwjsoc_cpu_b_oci_dct_packer_if.master bus
);
    localparam int BUF_W = ATOM_W * MAX_ATOMS;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENDED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;

    logic acc_full, atom_ready, accept, slot_free, handshake, transfer;

    // atom_ready is built only from registers; reset_n gates it low during reset
    assign acc_full   = (acc_cnt_q == CNT_W'(MAX_ATOMS));
    assign atom_ready = reset_n & (state_q == ST_RUN) & ~acc_full & ~flush_pend_q;
    assign accept     = bus.atom_valid & atom_ready;
    assign slot_free  = ~valid_q | bus.dct_ready;
    assign handshake  = valid_q & bus.dct_ready;
    assign transfer   = (acc_full | flush_pend_q | (state_q == ST_DRAIN))
                        & (acc_cnt_q != '0) & slot_free;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (test_ending_in) state_d = ST_DRAIN;
            ST_DRAIN: if ((acc_cnt_q == '0) && !valid_q) state_d = ST_ENDED;
            ST_ENDED: state_d = ST_ENDED;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        if (accept) begin
            for (int k = 0; k < MAX_ATOMS; k++) begin
                if (acc_cnt_q == CNT_W'(k)) acc_d[k*ATOM_W +: ATOM_W] = bus.atom_data;
            end
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        // flush only matters if something (including this cycle's atom) is waiting
        if (flush && (state_q != ST_ENDED) && (acc_cnt_d != '0)) flush_pend_d = 1'b1;
        if (transfer) begin
            buf_d        = acc_q;
            cnt_d        = acc_cnt_q;
            valid_d      = 1'b1;
            acc_d        = '0;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b0;
        end else if (handshake) begin
            buf_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            buf_q        <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.atom_ready  = atom_ready;
    assign bus.dct_buffer  = buf_q;
    assign bus.dct_count   = cnt_q;
    assign bus.dct_valid   = valid_q;
    assign test_ending     = (state_q == ST_DRAIN);
    assign test_has_ended  = (state_q == ST_ENDED);
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_hwjsoc_cpu_b_oci_dct_packer.sv
// Bench for the OCI DCT packer: directed scenarios with literal packets plus
// randomized traffic compared every cycle against a packet-level reference model.
module tb_hwjsoc_cpu_b_oci_dct_packer;
    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       test_ending_in;
    logic       test_ending;
    logic       test_has_ended;
    logic [1:0] state_dbg;

    hwjsoc_cpu_b_oci_dct_packer_if bus_if ();

    hwjsoc_cpu_b_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .test_ending_in (test_ending_in),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .state_dbg      (state_dbg),
        .bus            (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          vectors;
    int          miscompares;
    int          hs_count;
    logic [33:0] exp_q[$];      // {count, buffer} of packets still to be delivered
    logic [33:0] last_emit;
    logic [29:0] m_cur_buf;     // atoms collected since the last packet boundary
    int          m_cur_n;
    bit          m_drain;
    bit          m_ended;
    bit          exp_valid;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic emit();
        last_emit = {4'(m_cur_n), m_cur_buf};
        exp_q.push_back(last_emit);
        m_cur_n   = 0;
        m_cur_buf = '0;
    endtask

    // Samples at negedge: outputs reflect the last posedge, inputs are what the next posedge sees.
    always @(negedge clk) begin : monitor
        int   pre;
        bit   hs;
        bit   take;
        bit   end_now;
        logic exp_ready;
        if (!reset_n) begin
            exp_q.delete();
            m_cur_n   = 0;
            m_cur_buf = '0;
            m_drain   = 0;
            m_ended   = 0;
            exp_valid = 0;
            check("reset_outputs", {bus_if.dct_valid, bus_if.dct_count, bus_if.dct_buffer,
                                    bus_if.atom_ready, test_ending, test_has_ended}, '0);
        end else begin
            check("dct_valid", bus_if.dct_valid, exp_valid);
            if (exp_valid && exp_q.size() > 0)
                check("dct_packet", {bus_if.dct_count, bus_if.dct_buffer}, exp_q[0]);
            else if (!exp_valid)
                check("dct_idle_zero", {bus_if.dct_count, bus_if.dct_buffer}, '0);
            exp_ready = !m_drain && !m_ended && (exp_q.size() == (exp_valid ? 1 : 0));
            check("atom_ready", bus_if.atom_ready, exp_ready);
            check("test_ending", test_ending, m_drain);
            check("test_has_ended", test_has_ended, m_ended);

            pre     = exp_q.size();
            hs      = bus_if.dct_valid && bus_if.dct_ready;
            take    = bus_if.atom_valid && bus_if.atom_ready;
            end_now = m_drain && (pre == 0) && !exp_valid;
            if (hs) begin
                hs_count++;
                if (pre > 0) void'(exp_q.pop_front());
            end
            if (take) begin
                m_cur_buf = m_cur_buf | ({28'd0, bus_if.atom_data} << (2 * m_cur_n));
                m_cur_n++;
            end
            if (m_cur_n == 15) emit();
            if (!m_drain && !m_ended) begin
                if (test_ending_in) begin
                    if (m_cur_n != 0) emit();
                    m_drain = 1;
                end else if (flush && m_cur_n != 0) begin
                    emit();
                end
            end
            if (end_now) begin
                m_drain = 0;
                m_ended = 1;
            end
            exp_valid = (pre - (hs ? 1 : 0)) >= 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_atom(input logic [1:0] d);
        int   guard;
        logic took;
        guard = 0;
        took  = 1'b0;
        bus_if.atom_valid = 1'b1;
        bus_if.atom_data  = d;
        while (!took && guard < 100) begin
            @(negedge clk);
            took = bus_if.atom_ready;
            tick();
            guard++;
        end
        bus_if.atom_valid = 1'b0;
        if (!took) check("atom_accept_timeout", took, 1);
    endtask

    task automatic pulse(input bit f, input bit t);
        flush          = f;
        test_ending_in = t;
        tick();
        flush          = 1'b0;
        test_ending_in = 1'b0;
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        bus_if.atom_valid = 1'b0;
        flush             = 1'b0;
        test_ending_in    = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_ended(input int max_cycles);
        int g;
        g = 0;
        while (!test_has_ended && g < max_cycles) begin
            tick();
            g++;
        end
        check("ended_timeout", test_has_ended, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int h0;
        int g;
        int ready_pct;
        vectors           = 0;
        miscompares       = 0;
        hs_count          = 0;
        reset_n           = 1'b0;
        flush             = 1'b0;
        test_ending_in    = 1'b0;
        bus_if.atom_valid = 1'b0;
        bus_if.atom_data  = 2'b00;
        bus_if.dct_ready  = 1'b1;
        do_reset();

        // full packet of repeating 01,10,11
        for (int i = 0; i < 15; i++) send_atom(2'(i % 3 + 1));
        check("t1_valid_not_yet", bus_if.dct_valid, 0);
        tick();
        check("t1_valid", bus_if.dct_valid, 1);
        check("t1_packet", {bus_if.dct_count, bus_if.dct_buffer}, {4'd15, 30'h39E79E79});
        check("t1_model_packet", last_emit, {4'd15, 30'h39E79E79});

        // partial packet via flush, next packet restarts at bit 0
        for (int i = 0; i < 3; i++) send_atom(2'b11);
        pulse(1, 0);
        check("t2_valid_not_yet", bus_if.dct_valid, 0);
        tick();
        check("t2_packet", {bus_if.dct_valid, bus_if.dct_count, bus_if.dct_buffer}, {1'b1, 4'd3, 30'h3F});
        send_atom(2'b01);
        pulse(1, 0);
        tick();
        check("t2_next_packet", {bus_if.dct_count, bus_if.dct_buffer}, {4'd1, 30'h1});
        repeat (3) tick();

        // backpressure: 30 atoms with consumer stalled
        bus_if.dct_ready = 1'b0;
        for (int i = 0; i < 30; i++) send_atom(2'b10);
        check("t3_ready_low", bus_if.atom_ready, 0);
        check("t3_held", {bus_if.dct_valid, bus_if.dct_count, bus_if.dct_buffer}, {1'b1, 4'd15, 30'h2AAAAAAA});
        repeat (5) tick();
        check("t3_still_held", {bus_if.dct_valid, bus_if.dct_count, bus_if.dct_buffer}, {1'b1, 4'd15, 30'h2AAAAAAA});
        h0 = hs_count;
        bus_if.dct_ready = 1'b1;
        g = 0;
        while ((hs_count - h0) < 2 && g < 20) begin
            tick();
            g++;
        end
        check("t3_packets_out", hs_count - h0, 2);
        repeat (2) tick();
        check("t3_drained", bus_if.dct_valid, 0);

        // end-of-test drain with a partial packet
        send_atom(2'b10);
        send_atom(2'b01);
        send_atom(2'b11);
        send_atom(2'b00);
        send_atom(2'b10);
        pulse(0, 1);
        check("t4_ending", {test_ending, bus_if.atom_ready}, 2'b10);
        tick();
        check("t4_packet", {bus_if.dct_valid, bus_if.dct_count, bus_if.dct_buffer}, {1'b1, 4'd5, 30'h236});
        wait_ended(20);
        check("t4_after_end", {bus_if.atom_ready, test_ending, bus_if.dct_valid}, 3'b000);
        pulse(1, 1);
        tick();
        check("t4_sticky", {test_has_ended, test_ending}, 2'b10);
        do_reset();

        // reset mid-packet
        bus_if.dct_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_atom(2'b01);
        for (int i = 0; i < 7; i++) send_atom(2'b11);
        check("t5_valid_before_reset", bus_if.dct_valid, 1);
        reset_n = 1'b0;
        #1;
        check("t5_async_clear", {bus_if.dct_valid, bus_if.dct_count, bus_if.dct_buffer,
                                 bus_if.atom_ready, test_ending, test_has_ended}, '0);
        repeat (2) tick();
        reset_n          = 1'b1;
        bus_if.dct_ready = 1'b1;
        send_atom(2'b11);
        send_atom(2'b11);
        pulse(1, 0);
        tick();
        check("t5_fresh_packet", {bus_if.dct_count, bus_if.dct_buffer}, {4'd2, 30'hF});
        repeat (3) tick();

        // flush with nothing pending, then end-of-test when idle
        pulse(1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_packet", bus_if.dct_valid, 0);
        end
        pulse(0, 1);
        check("t6_drain_cycle", {test_ending, test_has_ended}, 2'b10);
        tick();
        check("t6_ended", {test_ending, test_has_ended}, 2'b01);
        repeat (3) tick();
        check("t6_sticky", test_has_ended, 1);
        do_reset();

        // randomized traffic
        for (int r = 0; r < 6; r++) begin
            ready_pct = (r % 3 == 0) ? 90 : ((r % 3 == 1) ? 50 : 15);
            for (int c = 0; c < 300; c++) begin
                bus_if.atom_valid = ($urandom_range(0, 3) != 0);
                bus_if.atom_data  = 2'($urandom_range(0, 3));
                bus_if.dct_ready  = ($urandom_range(0, 99) < ready_pct);
                flush             = ($urandom_range(0, 15) == 0);
                if (r == 4 && c == 150) begin
                    reset_n = 1'b0;
                    tick();
                    tick();
                    reset_n = 1'b1;
                end
                tick();
            end
            flush             = 1'b0;
            test_ending_in    = 1'b1;
            bus_if.atom_valid = ($urandom_range(0, 1) != 0);
            tick();
            test_ending_in    = 1'b0;
            bus_if.atom_valid = 1'b0;
            bus_if.dct_ready  = 1'b1;
            wait_ended(100);
            for (int c = 0; c < 5; c++) begin
                flush          = ($urandom_range(0, 1) != 0);
                test_ending_in = ($urandom_range(0, 1) != 0);
                tick();
            end
            do_reset();
            bus_if.dct_ready = 1'b1;
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
